// File: rtl/maxpool_stream_pipe_if.sv
// Stream bundle for maxpool_stream_pipe: beat input side plus pooled output side.
// idx_o exists only when MAXPOOL_ARGMAX_EN is defined.
interface maxpool_stream_pipe_if #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4,
  parameter int unsigned beats_p = 1
);
  localparam int unsigned idx_w_lp = (els_p * beats_p > 1) ? $clog2(els_p * beats_p) : 1;

  logic                       v_i;
  logic [els_p*width_p-1:0]   data_i;
  logic                       ready_o;
  logic                       v_o;
  logic [width_p-1:0]         data_o;
  logic                       ready_i;
`ifdef MAXPOOL_ARGMAX_EN
  logic [idx_w_lp-1:0]        idx_o;
`endif

  // Pooling unit side
  modport slave (
    input  v_i,
    input  data_i,
    input  ready_i,
`ifdef MAXPOOL_ARGMAX_EN
    output idx_o,
`endif
    output ready_o,
    output v_o,
    output data_o
  );

  // Producer/consumer side
  modport master (
    output v_i,
    output data_i,
    output ready_i,
`ifdef MAXPOOL_ARGMAX_EN
    input  idx_o,
`endif
    input  ready_o,
    input  v_o,
    input  data_o
  );
endinterface

// File: rtl/maxpool_stream_pipe.sv
// Streaming max-pool: registered pairwise comparator tree, then a running max across beats_p beats.
// Define MAXPOOL_ARGMAX_EN to carry the window index of the maximum through to idx_o.
module maxpool_stream_pipe #(
  parameter int unsigned width_p  = 8,
  parameter int unsigned els_p    = 4,
  parameter int unsigned beats_p  = 1,
  parameter int unsigned signed_p = 0
) (
  input logic                  clk_i,
  input logic                  reset_i,
  maxpool_stream_pipe_if.slave bus
);
  localparam int unsigned levels_lp = $clog2(els_p);
  localparam int unsigned half_lp   = els_p / 2;
  localparam int unsigned cnt_w_lp  = (beats_p > 1) ? $clog2(beats_p) : 1;
`ifdef MAXPOOL_ARGMAX_EN
  localparam int unsigned idx_w_lp  = (els_p * beats_p > 1) ? $clog2(els_p * beats_p) : 1;
`endif

  // Strict greater-than: ties always resolve to the earlier lane / beat.
  function automatic logic gt(input logic [width_p-1:0] a, input logic [width_p-1:0] b);
    if (signed_p != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  logic en;

  // Tree registers: level k uses entries [0, els_p>>k).
  logic [width_p-1:0]   tree_q  [1:levels_lp][half_lp];
  logic [levels_lp:1]   tv_q;
  // Uniform view of every level, level 0 being the incoming beat.
  logic [width_p-1:0]   lvl_val [levels_lp+1][els_p];
  logic [levels_lp:0]   lvl_v;

  logic [width_p-1:0]   acc_q, data_q, res, merged;
  logic [cnt_w_lp-1:0]  cnt_q;
  logic                 v_q, res_v, last, take;

`ifdef MAXPOOL_ARGMAX_EN
  logic [levels_lp-1:0] lane_q   [1:levels_lp][half_lp];
  logic [levels_lp-1:0] lvl_lane [levels_lp+1][els_p];
  logic [idx_w_lp-1:0]  acc_idx_q, idx_q, merged_idx;
`endif

  assign en          = ~v_q | bus.ready_i;
  assign bus.ready_o = en;
  assign bus.v_o     = v_q;
  assign bus.data_o  = data_q;

  always_comb begin
    for (int j = 0; j < int'(els_p); j++) begin
      lvl_val[0][j] = bus.data_i[j*width_p +: width_p];
    end
    lvl_v[0] = bus.v_i;
    for (int k = 1; k <= int'(levels_lp); k++) begin
      for (int j = 0; j < int'(els_p); j++) begin
        lvl_val[k][j] = (j < int'(half_lp)) ? tree_q[k][j] : '0;
      end
      lvl_v[k] = tv_q[k];
    end

    res    = lvl_val[levels_lp][0];
    res_v  = lvl_v[levels_lp];
    last   = (cnt_q == cnt_w_lp'(beats_p - 1));
    take   = (cnt_q == '0) || gt(res, acc_q);
    merged = take ? res : acc_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 1; k <= int'(levels_lp); k++) begin
        for (int j = 0; j < int'(half_lp); j++) tree_q[k][j] <= '0;
      end
      tv_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      v_q    <= 1'b0;
      data_q <= '0;
    end else if (en) begin
      for (int k = 1; k <= int'(levels_lp); k++) begin
        tv_q[k] <= lvl_v[k-1];
        for (int j = 0; j < int'(half_lp); j++) begin
          tree_q[k][j] <= gt(lvl_val[k-1][2*j+1], lvl_val[k-1][2*j]) ?
                          lvl_val[k-1][2*j+1] : lvl_val[k-1][2*j];
        end
      end
      if (res_v) begin
        acc_q <= merged;
        cnt_q <= last ? '0 : cnt_q + cnt_w_lp'(1);
      end
      v_q <= res_v & last;
      if (res_v && last) data_q <= merged;
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  assign bus.idx_o = idx_q;

  always_comb begin
    for (int j = 0; j < int'(els_p); j++) lvl_lane[0][j] = levels_lp'(j);
    for (int k = 1; k <= int'(levels_lp); k++) begin
      for (int j = 0; j < int'(els_p); j++) begin
        lvl_lane[k][j] = (j < int'(half_lp)) ? lane_q[k][j] : '0;
      end
    end
    merged_idx = take ? (idx_w_lp'(cnt_q) * idx_w_lp'(els_p) +
                         idx_w_lp'(lvl_lane[levels_lp][0])) : acc_idx_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 1; k <= int'(levels_lp); k++) begin
        for (int j = 0; j < int'(half_lp); j++) lane_q[k][j] <= '0;
      end
      acc_idx_q <= '0;
      idx_q     <= '0;
    end else if (en) begin
      for (int k = 1; k <= int'(levels_lp); k++) begin
        for (int j = 0; j < int'(half_lp); j++) begin
          lane_q[k][j] <= gt(lvl_val[k-1][2*j+1], lvl_val[k-1][2*j]) ?
                          lvl_lane[k-1][2*j+1] : lvl_lane[k-1][2*j];
        end
      end
      if (res_v) acc_idx_q <= merged_idx;
      if (res_v && last) idx_q <= merged_idx;
    end
  end
`endif

endmodule

// File: tb/tb_maxpool_stream_pipe.sv
// Directed bench for maxpool_stream_pipe: four instances (default, signed, 2-beat, 3-beat windows).
// Index checks are compiled in only when MAXPOOL_ARGMAX_EN is defined.
module tb_maxpool_stream_pipe;
  logic        clk, rst, vld, rdy;
  logic [31:0] dat;
  int          sel;
  int          checks, failures;

  logic [3:0]  o_v, o_rdy;
  logic [7:0]  o_data [4];
  logic [7:0]  o_idx  [4];

  maxpool_stream_pipe_if #(.width_p(8), .els_p(4), .beats_p(1)) b0 ();
  maxpool_stream_pipe_if #(.width_p(8), .els_p(4), .beats_p(1)) b1 ();
  maxpool_stream_pipe_if #(.width_p(8), .els_p(4), .beats_p(2)) b2 ();
  maxpool_stream_pipe_if #(.width_p(8), .els_p(4), .beats_p(3)) b3 ();

  maxpool_stream_pipe #(.width_p(8), .els_p(4), .beats_p(1), .signed_p(0)) u0 (
    .clk_i(clk), .reset_i(rst), .bus(b0));
  maxpool_stream_pipe #(.width_p(8), .els_p(4), .beats_p(1), .signed_p(1)) u1 (
    .clk_i(clk), .reset_i(rst), .bus(b1));
  maxpool_stream_pipe #(.width_p(8), .els_p(4), .beats_p(2), .signed_p(0)) u2 (
    .clk_i(clk), .reset_i(rst), .bus(b2));
  maxpool_stream_pipe #(.width_p(8), .els_p(4), .beats_p(3), .signed_p(0)) u3 (
    .clk_i(clk), .reset_i(rst), .bus(b3));

  assign b0.v_i = vld && (sel == 0);
  assign b1.v_i = vld && (sel == 1);
  assign b2.v_i = vld && (sel == 2);
  assign b3.v_i = vld && (sel == 3);
  assign b0.data_i = dat;
  assign b1.data_i = dat;
  assign b2.data_i = dat;
  assign b3.data_i = dat;
  assign b0.ready_i = rdy;
  assign b1.ready_i = rdy;
  assign b2.ready_i = rdy;
  assign b3.ready_i = rdy;

  assign o_v   = {b3.v_o, b2.v_o, b1.v_o, b0.v_o};
  assign o_rdy = {b3.ready_o, b2.ready_o, b1.ready_o, b0.ready_o};
  assign o_data[0] = b0.data_o;
  assign o_data[1] = b1.data_o;
  assign o_data[2] = b2.data_o;
  assign o_data[3] = b3.data_o;
`ifdef MAXPOOL_ARGMAX_EN
  assign o_idx[0] = 8'(b0.idx_o);
  assign o_idx[1] = 8'(b1.idx_o);
  assign o_idx[2] = 8'(b2.idx_o);
  assign o_idx[3] = 8'(b3.idx_o);
`else
  assign o_idx[0] = 8'd0;
  assign o_idx[1] = 8'd0;
  assign o_idx[2] = 8'd0;
  assign o_idx[3] = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic [7:0]  exp_d;
    int          exp_i;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idx(input string name, input int d, input int exp);
`ifdef MAXPOOL_ARGMAX_EN
    chk(name, 32'(o_idx[d]), 32'(exp));
`endif
  endtask

  // Single beat with ready_i high: output must appear on exactly the third edge.
  task automatic apply_vec(input int d, input logic [31:0] data, input logic [7:0] exp_d,
                           input int exp_i);
    sel = d; dat = data; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0; dat = 32'hDEADBEEF;
    chk("lat_edge1_v", 32'(o_v[d]), 0);
    @(negedge clk);
    chk("lat_edge2_v", 32'(o_v[d]), 0);
    @(negedge clk);
    chk("lat_edge3_v", 32'(o_v[d]), 1);
    chk("vec_data", 32'(o_data[d]), 32'(exp_d));
    chk_idx("vec_idx", d, exp_i);
    @(negedge clk);
    chk("v_falls", 32'(o_v[d]), 0);
  endtask

  task automatic send(input int d, input logic [31:0] data);
    sel = d; dat = data; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_out(input string name, input int d, input logic [7:0] exp_d,
                          input int exp_i);
    int n = 0;
    while (!o_v[d] && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_v"}, 32'(o_v[d]), 1);
    chk({name, "_data"}, 32'(o_data[d]), 32'(exp_d));
    chk_idx({name, "_idx"}, d, exp_i);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_bp(input int i);
    logic [31:0] w = 32'h01010101;
    w[8*(i%4) +: 8] = 8'hA0 + 8'(i);
    return w;
  endfunction

  initial begin
    int sent, got, stall;
    bit started;
    checks = 0; failures = 0;
    vld = 1'b0; dat = '0; rdy = 1'b1; sel = 0; rst = 1'b1;

    vecs[0] = '{0, 32'h10807F05, 8'h80, 2};
    vecs[1] = '{0, 32'h55555555, 8'h55, 0};
    vecs[2] = '{0, 32'hFF018000, 8'hFF, 3};
    vecs[3] = '{0, 32'h00FF00FF, 8'hFF, 0};
    vecs[4] = '{0, 32'h01020304, 8'h04, 0};
    vecs[5] = '{1, 32'hFF018000, 8'h01, 2};
    vecs[6] = '{1, 32'h80808080, 8'h80, 0};
    vecs[7] = '{1, 32'h7F7F80FF, 8'h7F, 2};
    vecs[8] = '{1, 32'h00000000, 8'h00, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_v", 32'(o_v[d]), 0);
      chk("rst_data", 32'(o_data[d]), 0);
      chk("rst_ready", 32'(o_rdy[d]), 1);
      chk_idx("rst_idx", d, 0);
    end

    for (int i = 0; i < 9; i++) apply_vec(vecs[i].dut, vecs[i].data, vecs[i].exp_d, vecs[i].exp_i);

    // Three-beat window, back to back: only the final beat produces output.
    sel = 3; vld = 1'b1;
    dat = 32'h00201000; @(negedge clk); chk("w3_b0_nov", 32'(o_v[3]), 0);
    dat = 32'h11229033; @(negedge clk); chk("w3_b1_nov", 32'(o_v[3]), 0);
    dat = 32'h40000000; @(negedge clk); chk("w3_b2_nov", 32'(o_v[3]), 0);
    vld = 1'b0;
    @(negedge clk); chk("w3_edge2_nov", 32'(o_v[3]), 0);
    @(negedge clk);
    chk("w3_v", 32'(o_v[3]), 1);
    chk("w3_data", 32'(o_data[3]), 32'h90);
    chk_idx("w3_idx", 3, 5);
    @(negedge clk); chk("w3_fall", 32'(o_v[3]), 0);

    // Same window size with bubbles between beats and a cross-beat tie.
    send(3, 32'h30000000); @(negedge clk);
    send(3, 32'h00000030); @(negedge clk);
    send(3, 32'h10101010);
    wait_out("w3_bubble", 3, 8'h30, 3);

    // Two-beat tie keeps the earliest beat's lane 0.
    sel = 2; vld = 1'b1; dat = 32'h55555555;
    @(negedge clk); @(negedge clk);
    vld = 1'b0;
    wait_out("w2_tie", 2, 8'h55, 0);

    // Reset after the first beat of a two-beat window discards it.
    send(2, 32'h000000F0);
    rst = 1'b1;
    #1 chk("rst_mid_v", 32'(o_v[2]), 0);
    @(negedge clk); chk("rst_mid_v1", 32'(o_v[2]), 0);
    @(negedge clk); chk("rst_mid_v2", 32'(o_v[2]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(o_rdy[2]), 1);
    chk("rst_mid_v3", 32'(o_v[2]), 0);
    sel = 2; vld = 1'b1;
    dat = 32'h00003300; @(negedge clk);
    dat = 32'h44000000; @(negedge clk);
    vld = 1'b0;
    wait_out("rst_window", 2, 8'h44, 7);

    // Back-pressure: six beats, first result held for five cycles.
    sel = 0; sent = 0; got = 0; stall = 0; started = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (o_v[0] && !started) begin
        started = 1'b1;
        stall = 5;
      end
      rdy = (stall == 0);
      if (stall > 0) stall--;
      vld = (sent < 6);
      dat = mk_bp(sent);
      #1;
      if (!rdy) begin
        chk("bp_ready_low", 32'(o_rdy[0]), 0);
        chk("bp_v_held", 32'(o_v[0]), 1);
        chk("bp_data_held", 32'(o_data[0]), 32'hA0);
      end
      if (o_v[0] && rdy) begin
        chk("bp_order", 32'(o_data[0]), 32'(8'hA0 + 8'(got)));
        got++;
      end
      if (vld && o_rdy[0]) sent++;
      @(negedge clk);
    end
    vld = 1'b0; rdy = 1'b1;
    chk("bp_count", 32'(got), 6);
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_extra", 32'(o_v[0]), 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
